// File: rtl/sdes_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdes_pkg
// Shared widths, the arbiter FSM state type and a saturating counter helper
// for the SDES request arbiter slice.
// -----------------------------------------------------------------------------
package sdes_pkg;

    localparam int NONCE_W = 8;
    localparam int KEY_W   = 10;
    localparam int RN_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } sdes_arb_state_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sdes_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdes_req_arbiter_if
// Request/response bundle between the protocol engines and the arbiter.
//   req_valid  [NUM_REQ]      per-requester request valid
//   req_ready  [NUM_REQ]      per-requester accept (one-hot or zero)
//   req_nonce  [NUM_REQ*8]    packed nonces, lane i = [8i+7:8i]
//   req_key    [NUM_REQ*10]   packed keys,   lane i = [10i+9:10i]
//   rsp_valid / rsp_ready     response handshake
//   rsp_id     [ID_W]         owner of the response
//   rsp_rn     [8]            SDES result
// master = requester/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sdes_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import sdes_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*NONCE_W-1:0] req_nonce;
    logic [NUM_REQ*KEY_W-1:0]   req_key;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [RN_W-1:0]            rsp_rn;

    modport master (
        output req_valid, req_nonce, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rn
    );

    modport slave (
        input  req_valid, req_nonce, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rn
    );

endinterface

// File: rtl/sdes.sv
// -----------------------------------------------------------------------------
// sdes
// Combinational simplified-DES encryption core (8-bit block, 10-bit key).
//   nonce [8]   plaintext block
//   key   [10]  cipher key
//   rn    [8]   ciphertext, used as the random number
// Permutation tables are written with table bit 1 = vector MSB.
// -----------------------------------------------------------------------------
module sdes
    import sdes_pkg::*;
(
    input  logic [NONCE_W-1:0] nonce,
    input  logic [KEY_W-1:0]   key,
    output logic [RN_W-1:0]    rn
);

    // S-boxes flattened row-major; entry k sits at bits [2k+1:2k].
    localparam logic [31:0] S0_TBL = 32'hb7d8_1bb1;
    localparam logic [31:0] S1_TBL = 32'hc613_d2e4;

    function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] b);
        logic [3:0] idx;
        idx = {b[3], b[0], b[2], b[1]};    // row = outer bits, col = inner bits
        return tbl[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] x, input int n);
        logic [4:0] y;
        y = x;
        for (int i = 0; i < n; i++) begin
            y = {y[3:0], y[4]};
        end
        return y;
    endfunction

    // One Feistel round: left half mixed with F(right, subkey), right passes.
    function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
        logic [7:0] t;
        logic [3:0] s;
        logic [3:0] r;
        r = x[3:0];
        t = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
        s = {sbox(S0_TBL, t[7:4]), sbox(S1_TBL, t[3:0])};
        return {x[7:4] ^ {s[2], s[0], s[1], s[3]}, r};
    endfunction

    logic [9:0] p10_s;
    logic [4:0] l1_s;
    logic [4:0] r1_s;
    logic [7:0] k1_s;
    logic [7:0] k2_s;
    logic [7:0] ip_s;
    logic [7:0] rnd1_s;
    logic [7:0] rnd2_s;

    // Key schedule and two-round encryption.
    always_comb begin
        p10_s  = {key[7], key[5], key[8], key[3], key[6],
                  key[0], key[9], key[1], key[2], key[4]};
        l1_s   = rotl5(p10_s[9:5], 1);
        r1_s   = rotl5(p10_s[4:0], 1);
        k1_s   = p8({l1_s, r1_s});
        k2_s   = p8({rotl5(l1_s, 2), rotl5(r1_s, 2)});
        ip_s   = {nonce[6], nonce[2], nonce[5], nonce[7],
                  nonce[4], nonce[0], nonce[3], nonce[1]};
        rnd1_s = fk(ip_s, k1_s);
        rnd2_s = fk({rnd1_s[3:0], rnd1_s[7:4]}, k2_s);
        rn     = {rnd2_s[4], rnd2_s[7], rnd2_s[5], rnd2_s[3],
                  rnd2_s[1], rnd2_s[6], rnd2_s[0], rnd2_s[2]};
    end

endmodule

// File: rtl/sdes_req_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted req at or after ptr,
// wrapping modulo N.
//   req        [N]         request vector
//   ptr        [IDX_W]     highest-priority index
//   gnt_onehot [N]         one-hot grant, zero when no request
//   gnt_idx    [IDX_W]     index of the grant (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        for (int off = 0; off < N; off++) begin
            cand_s = IDX_W'((int'(ptr) + off) % N);
            if (!found_s && req[cand_s]) begin
                found_s            = 1'b1;
                gnt_onehot[cand_s] = 1'b1;
                gnt_idx            = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sdes_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdes_req_arbiter
// Shares one combinational SDES core among NUM_REQ requesters. Round-robin
// accept in IDLE, compute in CALC, hold the tagged result in RESP until
// consumed.
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        sdes_req_arbiter_if.slave (request lanes + response channel)
//   grant_cnt  [NUM_REQ*16] saturating per-requester accept counters,
//              present only when SDES_GRANT_CNT_EN is defined
// -----------------------------------------------------------------------------
module sdes_req_arbiter
    import sdes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdes_req_arbiter_if.slave     bus
`ifdef SDES_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    sdes_arb_state_t    state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [NONCE_W-1:0] nonce_r;
    logic [KEY_W-1:0]   key_r;
    logic               rsp_valid_r;
    logic [RN_W-1:0]    rsp_rn_r;

    logic [NUM_REQ-1:0] gnt_onehot_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic [NONCE_W-1:0] sel_nonce_s;
    logic [KEY_W-1:0]   sel_key_s;
    logic [RN_W-1:0]    rn_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req        (bus.req_valid),
        .ptr        (rr_ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s)
    );

    // Only the latched operands feed the core, so lane changes after accept
    // cannot disturb the result in flight.
    sdes u_sdes (
        .nonce (nonce_r),
        .key   (key_r),
        .rn    (rn_s)
    );

    // AND-OR mux of the winning requester's nonce/key lanes.
    always_comb begin
        sel_nonce_s = '0;
        sel_key_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot_s[i]) begin
                sel_nonce_s = sel_nonce_s | bus.req_nonce[i*NONCE_W +: NONCE_W];
                sel_key_s   = sel_key_s   | bus.req_key[i*KEY_W +: KEY_W];
            end else begin
                sel_nonce_s = sel_nonce_s;
                sel_key_s   = sel_key_s;
            end
        end
    end

    // The accept handshake completes in the same cycle, so ready is the
    // arbiter grant gated by IDLE.
    assign bus.req_ready = (state_r == IDLE) ? gnt_onehot_s : '0;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_rn    = rsp_rn_r;

    // Arbiter FSM with operand latches, response registers and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            nonce_r     <= '0;
            key_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rn_r    <= '0;
`ifdef SDES_GRANT_CNT_EN
            grant_cnt   <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.req_valid) begin
                        nonce_r <= sel_nonce_s;
                        key_r   <= sel_key_s;
                        id_r    <= gnt_idx_s;
                        state_r <= CALC;
`ifdef SDES_GRANT_CNT_EN
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (gnt_onehot_s[i]) begin
                                grant_cnt[i*16 +: 16] <= sat_inc16(grant_cnt[i*16 +: 16]);
                            end else begin
                                grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16];
                            end
                        end
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rsp_rn_r    <= rn_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        // Next search starts just after the requester served.
                        if (id_r == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr_r <= '0;
                        end else begin
                            rr_ptr_r <= id_r + ID_W'(1);
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_req_arbiter.sv
module tb_sdes_req_arbiter;
    import sdes_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sdes_req_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

`ifdef SDES_GRANT_CNT_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    sdes_req_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
`ifdef SDES_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        logic [3:0]  mask;
        logic [31:0] nonce;
        logic [39:0] key;
        logic [1:0]  exp_id;
        logic [7:0]  exp_rn;
    } vec_t;

    vec_t vecs[13];

    logic [31:0] std_nonce;
    logic [39:0] std_key;
    logic [31:0] one_nonce;
    logic [39:0] one_key;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_nonce = '0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Full transaction with the consumer always ready: accept, CALC, RESP, consume.
    task automatic run_txn(input string tag, input logic [3:0] mask, input logic [31:0] n,
                           input logic [39:0] k, input logic [1:0] exp_id, input logic [7:0] exp_rn);
        logic [3:0] exp_rdy;
        exp_rdy       = 4'b0001 << exp_id;
        bus.req_valid = mask;
        bus.req_nonce = n;
        bus.req_key   = k;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, " req_ready@accept"}, 64'(bus.req_ready), 64'(exp_rdy));
        tick();
        bus.req_valid = '0;
        #1;
        chk({tag, " req_ready@calc"}, 64'(bus.req_ready), 64'd0);
        chk({tag, " rsp_valid@calc"}, 64'(bus.rsp_valid), 64'd0);
        tick();
        chk({tag, " rsp_valid@resp"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(exp_id));
        chk({tag, " rsp_rn"}, 64'(bus.rsp_rn), 64'(exp_rn));
        tick();
        chk({tag, " rsp_valid@done"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        std_nonce = {8'hd2, 8'hb1, 8'h11, 8'hff};
        std_key   = {10'h1a2, 10'h102, 10'h001, 10'h3ff};
        one_nonce = {8'hd2, 8'hb1, 8'h11, 8'h00};
        one_key   = {10'h1a2, 10'h102, 10'h001, 10'h000};

        vecs[0]  = '{1'b0, 4'b0001, one_nonce, one_key, 2'd0, 8'hf0};
        vecs[1]  = '{1'b1, 4'b1111, std_nonce, std_key, 2'd0, 8'h0f};
        vecs[2]  = '{1'b0, 4'b1111, std_nonce, std_key, 2'd1, 8'hc3};
        vecs[3]  = '{1'b0, 4'b1111, std_nonce, std_key, 2'd2, 8'hb0};
        vecs[4]  = '{1'b0, 4'b1111, std_nonce, std_key, 2'd3, 8'h49};
        vecs[5]  = '{1'b0, 4'b1111, std_nonce, std_key, 2'd0, 8'h0f};
        vecs[6]  = '{1'b0, 4'b1110, std_nonce, std_key, 2'd1, 8'hc3};
        vecs[7]  = '{1'b0, 4'b1100, std_nonce, std_key, 2'd2, 8'hb0};
        vecs[8]  = '{1'b0, 4'b1000, std_nonce, std_key, 2'd3, 8'h49};
        vecs[9]  = '{1'b0, 4'b1010, std_nonce, std_key, 2'd1, 8'hc3};
        vecs[10] = '{1'b0, 4'b0011, std_nonce, std_key, 2'd0, 8'h0f};
        vecs[11] = '{1'b0, 4'b0100, std_nonce, std_key, 2'd2, 8'hb0};
        vecs[12] = '{1'b0, 4'b0001, std_nonce, std_key, 2'd0, 8'h0f};

        // Reset state.
        do_reset();
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("reset rsp_rn", 64'(bus.rsp_rn), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset state", 64'(dut.state_r), 64'(IDLE));
        chk("reset rr_ptr", 64'(dut.rr_ptr_r), 64'd0);

        // Table-driven transactions.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_rst) begin
                do_reset();
            end
            run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].nonce, vecs[i].key,
                    vecs[i].exp_id, vecs[i].exp_rn);
        end

        // Backpressure: response held 5 cycles, pending requester 1 waits.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_nonce = std_nonce;
        bus.req_key   = std_key;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp req_ready@accept", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("bp req_ready@calc", 64'(bus.req_ready), 64'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp rsp_valid hold", 64'(bus.rsp_valid), 64'd1);
            chk("bp rsp_id hold", 64'(bus.rsp_id), 64'd0);
            chk("bp rsp_rn hold", 64'(bus.rsp_rn), 64'h0f);
            chk("bp req_ready hold", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp rsp_valid consumed", 64'(bus.rsp_valid), 64'd0);
        chk("bp pending req_ready", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        chk("bp second rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp second rsp_id", 64'(bus.rsp_id), 64'd1);
        chk("bp second rsp_rn", 64'(bus.rsp_rn), 64'hc3);
        tick();
        chk("bp second consumed", 64'(bus.rsp_valid), 64'd0);

        // Operand change after accept must not affect the result.
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_nonce = {8'hd2, 24'h0};
        bus.req_key   = {10'h1b2, 30'h0};
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = '0;
        bus.req_nonce = 32'h0;
        tick();
        chk("chg rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("chg rsp_id", 64'(bus.rsp_id), 64'd3);
        chk("chg rsp_rn", 64'(bus.rsp_rn), 64'h09);
        tick();

        // Reset during CALC: no response, pointer back to 0.
        run_txn("pre_rst", 4'b0010, std_nonce, std_key, 2'd1, 8'hc3);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        chk("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst state", 64'(dut.state_r), 64'(IDLE));
        chk("midrst rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst no response", 64'(bus.rsp_valid), 64'd0);
        end
        run_txn("post_rst", 4'b1111, std_nonce, std_key, 2'd0, 8'h0f);

`ifdef SDES_GRANT_CNT_EN
        do_reset();
        chk("cnt reset", 64'(grant_cnt), 64'd0);
        for (int t = 0; t < 3; t++) begin
            run_txn("cnt r2", 4'b0100, std_nonce, std_key, 2'd2, 8'hb0);
        end
        chk("cnt after 3", 64'(grant_cnt), 64'h0000_0003_0000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdes_req_arbiter.md
Name: sdes_req_arbiter

Overview:
- Shares one instance of the existing combinational SDES core (nonce[7:0], key[9:0] -> rn[7:0]) between NUM_REQ requesters.
- Round-robin grant; the winner's nonce/key are registered and the SDES output is registered.
- The result returns on a single tagged response channel with a valid/ready handshake.
- Sits between the protocol engines that need random numbers and the SDES datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_nonce  in  NUM_REQ*8  packed nonces; requester i uses [8i+7:8i].
- req_key  in  NUM_REQ*10  packed keys; requester i uses [10i+9:10i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_rn  out  8  SDES result.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_rn=0.
  - Nonce, key and id latches cleared.
  - Reset mid-operation aborts the transaction; no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If |req_valid, pick the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready[win] combinationally in this cycle. The handshake completes this cycle.
  - Latch nonce, key and id=win. Go to CALC.
  - If no request is valid, stay in IDLE with req_ready=0.
- CALC:
  - The registered nonce/key drive SDES.
  - Capture rn into rsp_rn at this edge. Set rsp_valid=1. Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_rn stable until rsp_ready=1.
  - On the edge where rsp_valid&&rsp_ready: rsp_valid=0, rr_ptr=(id+1) mod NUM_REQ, go to IDLE.
- req_ready is 0 in CALC and RESP. Requests arriving then wait and are never dropped.
- Latency: accept at cycle N, rsp_valid high at N+2. Minimum 3 cycles per transaction; back-to-back accepts are possible one cycle after a response is consumed.
- Fairness: a requester that stays valid is granted within NUM_REQ transactions.
- A requester deasserting req_valid before being granted is legal; nothing is recorded for it.
- Inputs are sampled only in the accept cycle. Later changes to nonce/key do not affect the in-flight result.
- rsp_ready high while rsp_valid=0 is ignored.

Optional Feature:
- Macro: SDES_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, NUM_REQ*16 packed.
  - Counter i increments on each accept for requester i and saturates at 16'hFFFF.
  - Counters clear on reset.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Package sdes_pkg:
  - NONCE_W=8, KEY_W=10, RN_W=8.
  - typedef enum logic [1:0] {IDLE, CALC, RESP} sdes_arb_state_t.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N] and ptr; outputs gnt_onehot and gnt_idx. Purely combinational.
- SDES is instantiated unchanged.

Test Plan:
- Single request: requester 0 valid with nonce=8'h00, key=10'h000. Expect req_ready[0] the same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_rn=8'hf0.
- All 4 valid simultaneously, each with its own vector:
  - r0: ff/3ff -> 0f
  - r1: 11/001 -> c3
  - r2: b1/102 -> b0
  - r3: d2/1a2 -> 49
  - Expect responses in id order 0,1,2,3 with matching rn. A second round starting at rr_ptr=0 repeats the same order.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. rsp_valid/rsp_id/rsp_rn stay stable, req_ready stays 0, and a pending request is served only after the response is consumed.
- Input change after accept: nonce changes from 8'hd2 to 8'h00 one cycle after accept, key=10'h1b2. rsp_rn=8'h09 (the original nonce's result).
- Reset mid-operation: rst_n=0 in CALC. Next cycle: rsp_valid=0, state=IDLE, rr_ptr=0, no response emitted.
- With SDES_GRANT_CNT_EN: 3 transactions from requester 2. grant_cnt[47:32]=3 and all other counters 0.
